ahbl_mem_scoreboard: RTL and testbench

//  Passive, synthesisable AHB-Lite memory-contract monitor. Tracks N_TRACK byte

---
 rtl/ahbl_mem_scoreboard.sv | 189 ++++++++++++++++++
 tb/tb_ahbl_mem_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_mem_scoreboard.sv
// AHB-Lite memory-contract monitor: shadows tracked bytes, checks reads against last write (AHBL_SCOREBOARD_PROTO_CHECK_EN adds a protocol checker).
// Latency: mismatch/proto_err registered, one cycle after the completing edge.
// Backpressure: passive observer; follows hready stalls, never drives the bus.
module ahbl_mem_scoreboard #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int N_TRACK = 4,
  parameter int W_CNT   = 16,
  localparam int W_IDX  = (N_TRACK > 1) ? $clog2(N_TRACK) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [N_TRACK*W_ADDR-1:0]   track_addr,
  input  logic                        hready,
  input  logic                        hresp,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [W_ADDR-1:0]           haddr,
  input  logic [2:0]                  hsize,
  input  logic [W_DATA-1:0]           hwdata,
  input  logic [W_DATA-1:0]           hrdata,
  output logic [N_TRACK-1:0]          shadow_vld,
  output logic                        mismatch,
  output logic [W_IDX-1:0]            mismatch_idx,
  output logic [7:0]                  mismatch_exp,
  output logic [7:0]                  mismatch_got,
  output logic                        err_sticky,
  output logic [W_CNT-1:0]            check_cnt
`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
  ,
  output logic                        proto_err
`endif
);

  localparam int NB    = W_DATA / 8;
  localparam int W_SUM = $clog2(N_TRACK + 1);
  localparam int W_EXT = W_CNT + W_SUM;

  logic                         dph_active;
  logic                         dph_write;
  logic [W_ADDR-1:0]            dph_addr;
  logic [2:0]                   dph_size;
  logic                         done;
  logic                         err_done;
  logic [N_TRACK-1:0]           ovl;
  logic [N_TRACK-1:0]           cmp;
  logic [N_TRACK-1:0]           fail;
  logic [N_TRACK-1:0][7:0]      wbyte;
  logic [N_TRACK-1:0][7:0]      rbyte;
  logic [N_TRACK-1:0][7:0]      shadow;
  logic [W_IDX-1:0]             fail_idx;
  logic [7:0]                   fail_exp;
  logic [7:0]                   fail_got;
  logic [W_SUM-1:0]             cmp_sum;
  logic [W_EXT-1:0]             cnt_ext;
  logic [W_CNT-1:0]             cnt_next;
  logic                         proto_hit;

  assign done     = dph_active && hready && !hresp;
  assign err_done = dph_active && hready && hresp;

  // Overlap is evaluated one bit wider than the address so the top block never wraps.
  for (genvar i = 0; i < N_TRACK; i++) begin : g_ch
    logic [W_ADDR-1:0] ta;
    logic [W_ADDR:0]   span;
    logic [W_ADDR:0]   lo;
    logic [W_ADDR-1:0] lane_sh;

    assign ta       = track_addr[i*W_ADDR +: W_ADDR];
    assign span     = (W_ADDR+1)'(1) << dph_size;
    assign lo       = {1'b0, dph_addr} & ~(span - (W_ADDR+1)'(1));
    assign ovl[i]   = ({1'b0, ta} >= lo) && ({1'b0, ta} < lo + span);
    assign lane_sh  = (ta & W_ADDR'(NB - 1)) << 3;
    assign wbyte[i] = 8'(hwdata >> lane_sh);
    assign rbyte[i] = 8'(hrdata >> lane_sh);
    assign cmp[i]   = done && !dph_write && ovl[i] && shadow_vld[i];
    assign fail[i]  = cmp[i] && (rbyte[i] != shadow[i]);
  end

  always_comb begin
    fail_idx = '0;
    fail_exp = '0;
    fail_got = '0;
    for (int i = N_TRACK - 1; i >= 0; i--) begin
      if (fail[i]) begin
        fail_idx = W_IDX'(i);
        fail_exp = shadow[i];
        fail_got = rbyte[i];
      end
    end
  end

  always_comb begin
    cmp_sum = '0;
    for (int i = 0; i < N_TRACK; i++) cmp_sum = cmp_sum + W_SUM'(cmp[i]);
    cnt_ext  = W_EXT'(check_cnt) + W_EXT'(cmp_sum);
    cnt_next = (cnt_ext > W_EXT'({W_CNT{1'b1}})) ? {W_CNT{1'b1}} : cnt_ext[W_CNT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dph_active   <= 1'b0;
      dph_write    <= 1'b0;
      dph_addr     <= '0;
      dph_size     <= '0;
      shadow       <= '0;
      shadow_vld   <= '0;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
      mismatch_exp <= '0;
      mismatch_got <= '0;
      err_sticky   <= 1'b0;
      check_cnt    <= '0;
    end else begin
      if (hready) begin
        dph_active <= htrans[1];
        dph_write  <= hwrite;
        dph_addr   <= haddr;
        dph_size   <= hsize;
      end
      for (int i = 0; i < N_TRACK; i++) begin
        if (clr) begin
          shadow_vld[i] <= 1'b0;
        end else if (done && dph_write && ovl[i]) begin
          shadow[i]     <= wbyte[i];
          shadow_vld[i] <= 1'b1;
        end else if (err_done && dph_write && ovl[i]) begin
          shadow_vld[i] <= 1'b0;
        end
      end
      mismatch <= |fail;
      if (|fail) begin
        mismatch_idx <= fail_idx;
        mismatch_exp <= fail_exp;
        mismatch_got <= fail_got;
      end
      err_sticky <= err_sticky | (|fail) | proto_hit;
      check_cnt  <= cnt_next;
    end
  end

`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
  logic              prv_addr_stall;
  logic              prv_wstall;
  logic              prv_resp1;
  logic [1:0]        prv_htrans;
  logic              prv_hwrite;
  logic [W_ADDR-1:0] prv_haddr;
  logic [2:0]        prv_hsize;
  logic [W_DATA-1:0] prv_hwdata;
  logic [W_ADDR-1:0] size_mask;

  assign size_mask = (W_ADDR'(1) << hsize) - W_ADDR'(1);
  assign proto_hit =
      (prv_addr_stall && (htrans != prv_htrans || hwrite != prv_hwrite ||
                          haddr != prv_haddr || hsize != prv_hsize)) ||
      (prv_wstall && (hwdata != prv_hwdata)) ||
      (htrans[1] && ((haddr & size_mask) != '0)) ||
      (hresp && hready && !prv_resp1);

  always_ff @(posedge clk) begin
    if (rst) begin
      prv_addr_stall <= 1'b0;
      prv_wstall     <= 1'b0;
      prv_resp1      <= 1'b0;
      prv_htrans     <= '0;
      prv_hwrite     <= 1'b0;
      prv_haddr      <= '0;
      prv_hsize      <= '0;
      prv_hwdata     <= '0;
      proto_err      <= 1'b0;
    end else begin
      prv_addr_stall <= htrans[1] && !hready;
      prv_wstall     <= dph_active && dph_write && !hready;
      prv_resp1      <= hresp && !hready;
      prv_htrans     <= htrans;
      prv_hwrite     <= hwrite;
      prv_haddr      <= haddr;
      prv_hsize      <= hsize;
      prv_hwdata     <= hwdata;
      proto_err      <= proto_hit;
    end
  end
`else
  assign proto_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_mem_scoreboard.sv
// Bench for ahbl_mem_scoreboard: directed vector table, hand-written corner sequences,
// then random AHB-Lite traffic against a transaction-level byte model.
module tb_ahbl_mem_scoreboard;
  localparam int W_ADDR = 32, W_DATA = 32, N_TRACK = 4, W_CNT = 4, W_IDX = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, clr, hready, hresp, hwrite;
  logic [1:0]                htrans;
  logic [W_ADDR-1:0]         haddr;
  logic [2:0]                hsize;
  logic [W_DATA-1:0]         hwdata, hrdata;
  logic [N_TRACK*W_ADDR-1:0] track_addr;
  logic [N_TRACK-1:0]        shadow_vld;
  logic                      mismatch, err_sticky;
  logic [W_IDX-1:0]          mismatch_idx;
  logic [7:0]                mismatch_exp, mismatch_got;
  logic [W_CNT-1:0]          check_cnt;
`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
  logic                      proto_err;
`endif

  ahbl_mem_scoreboard #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .N_TRACK(N_TRACK), .W_CNT(W_CNT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .track_addr(track_addr),
    .hready(hready), .hresp(hresp), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
    .shadow_vld(shadow_vld), .mismatch(mismatch), .mismatch_idx(mismatch_idx),
    .mismatch_exp(mismatch_exp), .mismatch_got(mismatch_got),
    .err_sticky(err_sticky), .check_cnt(check_cnt)
`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    bit          err;
    logic [3:0]  vld;
    bit          mm;
    logic [1:0]  idx;
    logic [7:0]  mexp;
    logic [7:0]  mgot;
    logic [3:0]  cnt;
    bit          sticky;
  } vec_t;
  vec_t vt[14];

  // Transaction-level expectations: byte shadows, valid bits, saturating count.
  logic [7:0]  m_sh  [N_TRACK];
  bit          m_vld [N_TRACK];
  logic [31:0] m_trk [N_TRACK];
  int          m_cnt;
  bit          m_sticky;
  logic [7:0]  mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; hready = 1'b1; hresp = 1'b0; htrans = 2'b00;
    hwrite = 1'b0; haddr = '0; hsize = 3'd0; hwdata = '0; hrdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input logic [31:0] rd, input int waits,
                      input bit err, input bit clr_end);
    htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size; hready = 1'b1; hresp = 1'b0;
    hwdata = $urandom; hrdata = $urandom;
    tick();
    htrans = 2'b00; hwdata = wd;
    for (int k = 0; k < waits; k++) begin
      hready = 1'b0; hrdata = ~rd;
      tick();
      chk("stall_no_mismatch", {31'd0, mismatch}, 32'd0);
    end
    if (err) begin
      hready = 1'b0; hresp = 1'b1;
      tick();
    end
    hready = 1'b1; hresp = err; hrdata = rd; clr = clr_end;
    tick();
    hresp = 1'b0; clr = 1'b0;
  endtask

  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wd, input logic [31:0] rd, input bit err,
                            input bit clr_end, output bit mm, output int idx,
                            output logic [7:0] e, output logic [7:0] g);
    longint unsigned n, lo, t;
    int lane;
    logic [7:0] rb;
    mm = 1'b0; idx = 0; e = '0; g = '0;
    n  = 64'd1 << size;
    lo = longint'(addr) - (longint'(addr) % n);
    for (int i = 0; i < N_TRACK; i++) begin
      t    = longint'(m_trk[i]);
      lane = int'(t % 4);
      rb   = 8'(rd >> (8 * lane));
      if (t >= lo && t < lo + n) begin
        if (!err && wr) begin
          m_sh[i] = 8'(wd >> (8 * lane)); m_vld[i] = 1'b1;
        end else if (!err && m_vld[i]) begin
          if (m_cnt < 15) m_cnt++;
          if (rb != m_sh[i] && !mm) begin
            mm = 1'b1; idx = i; e = m_sh[i]; g = rb;
          end
        end else if (err && wr) begin
          m_vld[i] = 1'b0;
        end
      end
    end
    if (clr_end) for (int i = 0; i < N_TRACK; i++) m_vld[i] = 1'b0;
    if (mm) m_sticky = 1'b1;
  endtask

  function automatic logic [3:0] m_vld_vec();
    logic [3:0] v;
    for (int i = 0; i < N_TRACK; i++) v[i] = m_vld[i];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ch0=0x12, ch1=0x21, ch2=0x80, ch3=0x12 (duplicate of ch0)
    vt[0]  = '{1, 32'h10, 2, 32'hA1B2C3D4, 32'h0,        0, 0, 4'b1001, 0, 0, 8'h00, 8'h00, 0, 0};
    vt[1]  = '{0, 32'h10, 2, 32'h0,        32'hA1B2C3D4, 0, 0, 4'b1001, 0, 0, 8'h00, 8'h00, 2, 0};
    vt[2]  = '{1, 32'h12, 0, 32'h005E0000, 32'h0,        1, 0, 4'b1001, 0, 0, 8'h00, 8'h00, 2, 0};
    vt[3]  = '{0, 32'h10, 2, 32'h0,        32'h00000000, 0, 0, 4'b1001, 1, 0, 8'h5E, 8'h00, 4, 1};
    vt[4]  = '{1, 32'h20, 1, 32'h0000CD77, 32'h0,        0, 0, 4'b1011, 0, 0, 8'h00, 8'h00, 4, 1};
    vt[5]  = '{0, 32'h20, 2, 32'h0,        32'h0000CD77, 3, 0, 4'b1011, 0, 0, 8'h00, 8'h00, 5, 1};
    vt[6]  = '{1, 32'h12, 0, 32'h00990000, 32'h0,        0, 1, 4'b0010, 0, 0, 8'h00, 8'h00, 5, 1};
    vt[7]  = '{0, 32'h12, 0, 32'h0,        32'hFFFFFFFF, 0, 0, 4'b0010, 0, 0, 8'h00, 8'h00, 5, 1};
    vt[8]  = '{0, 32'h20, 1, 32'h0,        32'h0000CC77, 0, 0, 4'b0010, 1, 1, 8'hCD, 8'hCC, 6, 1};
    vt[9]  = '{0, 32'h80, 0, 32'h0,        32'h12345678, 0, 0, 4'b0010, 0, 0, 8'h00, 8'h00, 6, 1};
    vt[10] = '{0, 32'h20, 2, 32'h0,        32'h00000000, 1, 1, 4'b0010, 0, 0, 8'h00, 8'h00, 6, 1};
    vt[11] = '{1, 32'h7C, 2, 32'hFFFFFFFF, 32'h0,        0, 0, 4'b0010, 0, 0, 8'h00, 8'h00, 6, 1};
    vt[12] = '{1, 32'h80, 2, 32'h000000AA, 32'h0,        0, 0, 4'b0110, 0, 0, 8'h00, 8'h00, 6, 1};
    vt[13] = '{0, 32'h80, 0, 32'h0,        32'h000000AA, 2, 0, 4'b0110, 0, 0, 8'h00, 8'h00, 7, 1};

    track_addr = {32'h12, 32'h80, 32'h21, 32'h12};
    do_reset();
    chk("rst_vld", {28'd0, shadow_vld}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_idx", {30'd0, mismatch_idx}, 32'd0);
    chk("rst_exp", {24'd0, mismatch_exp}, 32'd0);
    chk("rst_got", {24'd0, mismatch_got}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_cnt", {28'd0, check_cnt}, 32'd0);

    for (int k = 0; k < 14; k++) begin
      xfer(vt[k].wr, vt[k].addr, vt[k].size, vt[k].wd, vt[k].rd, vt[k].waits, vt[k].err, 1'b0);
      chk($sformatf("vec%0d_vld", k), {28'd0, shadow_vld}, {28'd0, vt[k].vld});
      chk($sformatf("vec%0d_mismatch", k), {31'd0, mismatch}, {31'd0, vt[k].mm});
      if (vt[k].mm) begin
        chk($sformatf("vec%0d_idx", k), {30'd0, mismatch_idx}, {30'd0, vt[k].idx});
        chk($sformatf("vec%0d_exp", k), {24'd0, mismatch_exp}, {24'd0, vt[k].mexp});
        chk($sformatf("vec%0d_got", k), {24'd0, mismatch_got}, {24'd0, vt[k].mgot});
      end
      chk($sformatf("vec%0d_cnt", k), {28'd0, check_cnt}, {28'd0, vt[k].cnt});
      chk($sformatf("vec%0d_sticky", k), {31'd0, err_sticky}, {31'd0, vt[k].sticky});
    end
    tick();
    chk("pulse_one_cycle", {31'd0, mismatch}, 32'd0);

    // Reset lands on the completing edge of a read that would otherwise mismatch.
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h80; hsize = 3'd0; hready = 1'b1; tick();
    htrans = 2'b00; hrdata = 32'h0; rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("midrst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("midrst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("midrst_cnt", {28'd0, check_cnt}, 32'd0);
    chk("midrst_vld", {28'd0, shadow_vld}, 32'd0);

    // clr together with a write completion: clr wins; count and sticky survive.
    track_addr = {32'h43, 32'h42, 32'h41, 32'h40};
    do_reset();
    xfer(1, 32'h40, 2, 32'h11223344, 32'h0, 0, 0, 0);
    chk("clr_pre_vld", {28'd0, shadow_vld}, 32'hF);
    xfer(0, 32'h40, 2, 32'h0, 32'h11223344, 0, 0, 0);
    chk("clr_pre_cnt", {28'd0, check_cnt}, 32'd4);
    xfer(0, 32'h40, 2, 32'h0, 32'h11223345, 0, 0, 0);
    chk("clr_mm", {31'd0, mismatch}, 32'd1);
    chk("clr_mm_exp", {24'd0, mismatch_exp}, 32'h44);
    chk("clr_mm_got", {24'd0, mismatch_got}, 32'h45);
    xfer(1, 32'h40, 2, 32'h55667788, 32'h0, 0, 0, 1);
    chk("clr_vld", {28'd0, shadow_vld}, 32'd0);
    chk("clr_cnt_kept", {28'd0, check_cnt}, 32'd8);
    chk("clr_sticky_kept", {31'd0, err_sticky}, 32'd1);
    xfer(0, 32'h40, 2, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    chk("clr_no_compare", {28'd0, check_cnt}, 32'd8);

    // Address-phase field change while stalled, then a misaligned NONSEQ.
    do_reset();
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h40; hsize = 3'd2; hready = 1'b0; tick();
    haddr = 32'h44; tick();
`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
    chk("proto_stall_chg", {31'd0, proto_err}, 32'd1);
    chk("proto_sticky", {31'd0, err_sticky}, 32'd1);
`else
    chk("noproto_sticky", {31'd0, err_sticky}, 32'd0);
`endif
    htrans = 2'b00; hready = 1'b1; tick(); tick();
`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
    chk("proto_pulse_end", {31'd0, proto_err}, 32'd0);
    do_reset();
`endif
    htrans = 2'b10; haddr = 32'h41; hsize = 3'd2; hready = 1'b1; tick();
    htrans = 2'b00; tick();
`ifdef AHBL_SCOREBOARD_PROTO_CHECK_EN
    chk("proto_misalign_sticky", {31'd0, err_sticky}, 32'd1);
`else
    chk("noproto_misalign_sticky", {31'd0, err_sticky}, 32'd0);
`endif

    // Random traffic over 0x40..0x4F with a duplicated channel.
    for (int i = 0; i < N_TRACK; i++) begin
      m_trk[i] = 32'h40 + ($urandom % 16);
      m_vld[i] = 1'b0; m_sh[i] = 8'h00;
    end
    m_trk[3] = m_trk[1];
    track_addr = {m_trk[3], m_trk[2], m_trk[1], m_trk[0]};
    m_cnt = 0; m_sticky = 1'b0;
    mem.delete();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      bit          wr, err, cl, mm;
      logic [2:0]  sz;
      logic [31:0] ad, wd, rd;
      int          wt, idx;
      logic [7:0]  e, g;
      wr = bit'($urandom % 2);
      sz = 3'($urandom % 3);
      ad = (32'h40 + ($urandom % 16)) & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      wt = int'($urandom % 3);
      err = ($urandom % 8) == 0;
      cl  = ($urandom % 16) == 0;
      rd = '0;
      for (int b = 0; b < 4; b++) begin
        logic [31:0] a;
        a = (ad & ~32'd3) + b;
        if (mem.exists(a)) rd[8*b +: 8] = mem[a];
      end
      if (($urandom % 5) == 0) rd[$urandom % 32] ^= 1'b1;
      model_xfer(wr, ad, sz, wd, rd, err, cl, mm, idx, e, g);
      if (wr && !err)
        for (int b = 0; b < (1 << sz); b++) mem[ad + b] = 8'(wd >> (8 * ((ad + b) % 4)));
      xfer(wr, ad, sz, wd, rd, wt, err, cl);
      chk("rnd_mismatch", {31'd0, mismatch}, {31'd0, mm});
      if (mm) begin
        chk("rnd_idx", {30'd0, mismatch_idx}, 32'(idx));
        chk("rnd_exp", {24'd0, mismatch_exp}, {24'd0, e});
        chk("rnd_got", {24'd0, mismatch_got}, {24'd0, g});
      end
      chk("rnd_vld", {28'd0, shadow_vld}, {28'd0, m_vld_vec()});
      chk("rnd_cnt", {28'd0, check_cnt}, 32'(m_cnt));
      chk("rnd_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
